// File: rtl/bus_decoder.sv
// System-bus decoder and read-data multiplexer for maxicore32.
// Decodes each processor request to one memory region or one IO register, runs
// per-region wait states or the device io_ready handshake, and reports
// unmapped, malformed or hung accesses through bus_error and error_address.
// ready and data_in are combinational: a device can complete in the same cycle
// it raises io_ready. All other outputs come straight from registers.
module bus_decoder #(
    parameter int unsigned          NUM_MEM  = 4,
    parameter int unsigned          NUM_IO   = 16,
    parameter logic [7:0]           IO_CLASS = 8'h0f,
    parameter logic [4*NUM_MEM-1:0] MEM_WAIT = {4{4'd0}},
    parameter int unsigned          TIMEOUT  = 255
) (
    input  logic                    clock,
    input  logic                    n_reset,
    input  logic [29:0]             address,
    input  logic                    read,
    input  logic                    write,
    output logic [NUM_MEM-1:0]      mem_cs,
    output logic [NUM_IO-1:0]       io_cs,
    input  logic [32*NUM_MEM-1:0]   mem_data_out,
    input  logic [32*NUM_IO-1:0]    io_data_out,
    input  logic [NUM_IO-1:0]       io_ready,
    output logic [31:0]             data_in,
    output logic                    ready,
    output logic                    bus_error,
    output logic [29:0]             error_address
);

    localparam int unsigned WAIT_W = 4;
    localparam int unsigned TMO_W  = 16;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_MEM-1:0]  mem_cs_d;
    logic [NUM_IO-1:0]   io_cs_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [29:0]         addr_q, addr_d;
    logic [29:0]         err_addr_d;
    logic                bus_error_d;
    logic                is_mem_q, is_mem_d;
    logic                dir_write_q, dir_write_d;

    // Address fields: byte-address bits [31:24] pick the class, [7:2] the IO register.
    logic [7:0]          addr_class;
    logic [5:0]          addr_reg;
    logic                mem_hit;
    logic                io_hit;
    logic [NUM_MEM-1:0]  mem_sel;
    logic [NUM_IO-1:0]   io_sel;
    logic [WAIT_W-1:0]   wait_load;
    logic                io_done;

    assign addr_class = address[29:22];
    assign addr_reg   = address[5:0];
    assign io_done    = |(io_cs & io_ready);

    // Decode the live request address into one-hot selects and the region wait count.
    always_comb begin
        mem_hit   = 32'(addr_class) < NUM_MEM;
        io_hit    = !mem_hit && (addr_class == IO_CLASS) && (32'(addr_reg) < NUM_IO);
        mem_sel   = '0;
        io_sel    = '0;
        wait_load = '0;
        for (int unsigned i = 0; i < NUM_MEM; i++) begin
            mem_sel[i] = mem_hit && (32'(addr_class) == i);
            if (mem_sel[i]) begin
                wait_load = MEM_WAIT[WAIT_W*i +: WAIT_W];
            end
        end
        for (int unsigned j = 0; j < NUM_IO; j++) begin
            io_sel[j] = io_hit && (32'(addr_reg) == j);
        end
    end

    // Next-state, select, counter and completion logic.
    always_comb begin
        state_d     = state_q;
        mem_cs_d    = mem_cs;
        io_cs_d     = io_cs;
        wait_d      = wait_q;
        tmo_d       = tmo_q;
        addr_d      = addr_q;
        err_addr_d  = error_address;
        is_mem_d    = is_mem_q;
        dir_write_d = dir_write_q;
        bus_error_d = 1'b0;
        ready       = 1'b0;

        case (state_q)
            IDLE: begin
                if (read || write) begin
                    addr_d      = address;
                    dir_write_d = write;
                    tmo_d       = '0;
                    wait_d      = '0;
                    if ((read ^ write) && (mem_hit || io_hit)) begin
                        state_d  = ACCESS;
                        mem_cs_d = mem_sel;
                        io_cs_d  = io_sel;
                        is_mem_d = mem_hit;
                        wait_d   = wait_load;
                    end else begin
                        // Unmapped or ambiguous request: fault without touching any device.
                        state_d     = DONE;
                        bus_error_d = 1'b1;
                        err_addr_d  = address;
                    end
                end
            end

            ACCESS: begin
                if (is_mem_q) begin
                    if (wait_q == '0) begin
                        ready    = 1'b1;
                        state_d  = DONE;
                        mem_cs_d = '0;
                        io_cs_d  = '0;
                    end else begin
                        wait_d = wait_q - WAIT_W'(1);
                    end
                end else if (io_done) begin
                    ready    = 1'b1;
                    state_d  = DONE;
                    mem_cs_d = '0;
                    io_cs_d  = '0;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    // Device never answered: abandon and report in the first DONE cycle.
                    state_d     = DONE;
                    bus_error_d = 1'b1;
                    err_addr_d  = addr_q;
                    tmo_d       = TMO_W'(TIMEOUT);
                    mem_cs_d    = '0;
                    io_cs_d     = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            DONE: begin
                mem_cs_d = '0;
                io_cs_d  = '0;
                if (!read && !write) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d  = IDLE;
                mem_cs_d = '0;
                io_cs_d  = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= IDLE;
            mem_cs        <= '0;
            io_cs         <= '0;
            wait_q        <= '0;
            tmo_q         <= '0;
            addr_q        <= '0;
            error_address <= '0;
            bus_error     <= 1'b0;
            is_mem_q      <= 1'b0;
            dir_write_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_cs        <= mem_cs_d;
            io_cs         <= io_cs_d;
            wait_q        <= wait_d;
            tmo_q         <= tmo_d;
            addr_q        <= addr_d;
            error_address <= err_addr_d;
            bus_error     <= bus_error_d;
            is_mem_q      <= is_mem_d;
            dir_write_q   <= dir_write_d;
        end
    end

    // Read-data mux: one-hot OR of the selected region, or the selected IO register on reads.
    always_comb begin
        data_in = '0;
        for (int unsigned i = 0; i < NUM_MEM; i++) begin
            if (mem_cs[i]) begin
                data_in = data_in | mem_data_out[DATA_W*i +: DATA_W];
            end
        end
        for (int unsigned j = 0; j < NUM_IO; j++) begin
            if (io_cs[j] && !dir_write_q) begin
                data_in = data_in | io_data_out[DATA_W*j +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_bus_decoder.sv
// Scoreboard bench for bus_decoder: the driver pushes the expected response of
// each request (from a spec-level model) and a monitor pops it on ready/bus_error.
module tb_bus_decoder;

    localparam int NUM_MEM = 4;
    localparam int NUM_IO  = 16;
    localparam int TIMEOUT = 10;
    localparam logic [7:0]  IO_CLASS = 8'h0f;
    localparam logic [15:0] MEM_WAIT = 16'h1230;

    logic                 clock;
    logic                 n_reset;
    logic [29:0]          address;
    logic                 read;
    logic                 write;
    logic [NUM_MEM-1:0]   mem_cs;
    logic [NUM_IO-1:0]    io_cs;
    logic [32*NUM_MEM-1:0] mem_data_out;
    logic [32*NUM_IO-1:0] io_data_out;
    logic [NUM_IO-1:0]    io_ready;
    logic [31:0]          data_in;
    logic                 ready;
    logic                 bus_error;
    logic [29:0]          error_address;

    logic [31:0] mem_data [NUM_MEM];
    logic [31:0] io_data  [NUM_IO];
    int          wait_tab [NUM_MEM] = '{0, 3, 2, 1};

    typedef struct {
        bit          is_err;
        logic [31:0] data;
        logic [29:0] err_addr;
        int          latency;
        int          cs_cycles;
        logic [3:0]  mem_cs;
        logic [15:0] io_cs;
        int          issue;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   cs_cnt   = 0;

    bus_decoder #(
        .NUM_MEM (NUM_MEM),
        .NUM_IO  (NUM_IO),
        .IO_CLASS(IO_CLASS),
        .MEM_WAIT(MEM_WAIT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock        (clock),
        .n_reset      (n_reset),
        .address      (address),
        .read         (read),
        .write        (write),
        .mem_cs       (mem_cs),
        .io_cs        (io_cs),
        .mem_data_out (mem_data_out),
        .io_data_out  (io_data_out),
        .io_ready     (io_ready),
        .data_in      (data_in),
        .ready        (ready),
        .bus_error    (bus_error),
        .error_address(error_address)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < NUM_MEM; i++) mem_data_out[32*i +: 32] = mem_data[i];
        for (int i = 0; i < NUM_IO; i++)  io_data_out[32*i +: 32]  = io_data[i];
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [29:0] wa(logic [31:0] b);
        return b[31:2];
    endfunction

    // Spec-level reference: class byte / register index -> response kind, latency, selects, data.
    function automatic exp_t model(logic [29:0] a, logic rd, logic wr, int dly);
        exp_t        e;
        logic [31:0] b;
        int          hi;
        int          j;
        b  = {a, 2'b00};
        hi = int'(b[31:24]);
        j  = int'(b[7:2]);
        e.is_err = 1'b0; e.data = '0; e.err_addr = '0; e.latency = 0;
        e.cs_cycles = 0; e.mem_cs = '0; e.io_cs = '0; e.issue = 0;
        if ((rd && wr) || !(hi < NUM_MEM || (hi == int'(IO_CLASS) && j < NUM_IO))) begin
            e.is_err   = 1'b1;
            e.err_addr = a;
            e.latency  = 1;
        end else if (hi < NUM_MEM) begin
            e.latency   = wait_tab[2'(hi)] + 1;
            e.cs_cycles = e.latency;
            e.mem_cs    = 4'(1 << hi);
            e.data      = mem_data[2'(hi)];
        end else begin
            e.io_cs = 16'(1 << j);
            if (dly >= TIMEOUT) begin
                e.is_err    = 1'b1;
                e.err_addr  = a;
                e.latency   = TIMEOUT + 1;
                e.cs_cycles = TIMEOUT;
            end else begin
                e.latency   = dly + 1;
                e.cs_cycles = e.latency;
                e.data      = rd ? io_data[4'(j)] : 32'h0;
            end
        end
        return e;
    endfunction

    // Monitor: checks selects every cycle and scores each ready/bus_error against the queue head.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (!n_reset) begin
            cs_cnt = 0;
        end else begin
            if (mem_cs != '0 || io_cs != '0) begin
                if (exp_q.size() == 0) begin
                    chk("cs_without_request", 64'({mem_cs, io_cs}), 64'(0));
                end else begin
                    chk("cs_select", 64'({mem_cs, io_cs}), 64'({exp_q[0].mem_cs, exp_q[0].io_cs}));
                    cs_cnt++;
                end
            end
            if (ready || bus_error) begin
                chk("ready_error_exclusive", 64'(ready & bus_error), 64'(0));
                if (exp_q.size() == 0) begin
                    chk("unexpected_response", 64'({ready, bus_error}), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_kind", 64'(bus_error), 64'(e.is_err));
                    chk("resp_latency", 64'(cyc - e.issue), 64'(e.latency));
                    chk("cs_cycles", 64'(cs_cnt), 64'(e.cs_cycles));
                    chk("data_in", 64'(data_in), 64'(e.data));
                    if (e.is_err) chk("error_address", 64'(error_address), 64'(e.err_addr));
                end
                cs_cnt = 0;
            end
        end
    end

    // One processor access: issue, scramble address once captured, stretch IO, hold in DONE, release.
    task automatic do_tx(logic [29:0] a, logic rd, logic wr, int dly);
        exp_t        e;
        int          n;
        bit          got;
        logic [31:0] b;
        int          j;
        e = model(a, rd, wr, dly);
        e.issue = cyc;
        exp_q.push_back(e);
        b = {a, 2'b00};
        j = int'(b[7:2]);
        io_ready = 16'($urandom);
        if (j < NUM_IO) io_ready[4'(j)] = 1'b0;
        address = a;
        read    = rd;
        write   = wr;
        n   = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clock); #1;
            n++;
            if (n == 1) address = 30'($urandom);
            if (j < NUM_IO && dly < TIMEOUT && n == dly + 1) io_ready[4'(j)] = 1'b1;
            @(negedge clock);
            got = ready || bus_error;
        end
        chk("response_seen", 64'(got), 64'(1));
        if (!got) exp_q.delete();
        repeat (2) begin
            @(posedge clock); #1;
        end
        read     = 1'b0;
        write    = 1'b0;
        io_ready = '0;
        @(posedge clock); #1;
    endtask

    task automatic check_quiet(string tag);
        chk({tag, "_mem_cs"}, 64'(mem_cs), 64'(0));
        chk({tag, "_io_cs"}, 64'(io_cs), 64'(0));
        chk({tag, "_ready"}, 64'(ready), 64'(0));
        chk({tag, "_bus_error"}, 64'(bus_error), 64'(0));
        chk({tag, "_data_in"}, 64'(data_in), 64'(0));
        chk({tag, "_error_address"}, 64'(error_address), 64'(0));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench watchdog expired");
    end

    initial begin : driver
        exp_t        e;
        logic [31:0] b;
        int          kind;
        int          hi;
        int          dly;
        logic        rd;
        logic        wr;

        n_reset  = 1'b0;
        address  = '0;
        read     = 1'b0;
        write    = 1'b0;
        io_ready = '0;
        for (int i = 0; i < NUM_MEM; i++) mem_data[i] = $urandom;
        for (int i = 0; i < NUM_IO; i++)  io_data[i]  = $urandom;

        repeat (2) @(posedge clock);
        #1;
        check_quiet("reset");
        n_reset = 1'b1;
        @(posedge clock); #1;

        // Directed cases.
        mem_data[0] = 32'hDEADBEEF;
        do_tx(wa(32'h0000_0010), 1'b1, 1'b0, 0);
        do_tx(wa(32'h0100_0020), 1'b1, 1'b0, 0);
        do_tx(wa(32'h0f00_0018), 1'b0, 1'b1, 5);
        do_tx(wa(32'h0f00_0008), 1'b1, 1'b0, 1000);
        do_tx(wa(32'h0700_0000), 1'b1, 1'b0, 0);
        do_tx(wa(32'h0000_0040), 1'b1, 1'b1, 0);
        do_tx(wa(32'h0f00_0040), 1'b1, 1'b0, 0);
        do_tx(wa(32'h0f00_0008), 1'b1, 1'b0, 0);

        // Reset in the middle of a 3-wait-state read.
        e = model(wa(32'h0100_0000), 1'b1, 1'b0, 0);
        e.issue = cyc;
        exp_q.push_back(e);
        address = wa(32'h0100_0000);
        read    = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("pre_reset_mem_cs", 64'(mem_cs), 64'(4'b0010));
        n_reset = 1'b0;
        #1;
        check_quiet("mid_access_reset");
        exp_q.delete();
        @(posedge clock); #1;
        read    = 1'b0;
        address = '0;
        @(posedge clock); #1;
        n_reset = 1'b1;
        @(posedge clock); #1;
        do_tx(wa(32'h0100_0004), 1'b1, 1'b0, 0);

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < NUM_MEM; i++) mem_data[i] = $urandom;
            for (int i = 0; i < NUM_IO; i++)  io_data[i]  = $urandom;
            kind = int'($urandom_range(0, 5));
            rd   = 1'($urandom_range(0, 1));
            wr   = !rd;
            dly  = 0;
            case (kind)
                0, 1: begin
                    hi = int'($urandom_range(0, NUM_MEM - 1));
                    b  = {8'(hi), 24'($urandom)};
                end
                2, 3: begin
                    b   = {IO_CLASS, 16'($urandom), 6'($urandom_range(0, NUM_IO - 1)), 2'b00};
                    dly = int'($urandom_range(0, 12));
                end
                4: begin
                    if ($urandom_range(0, 1) == 0) begin
                        do hi = int'($urandom_range(NUM_MEM, 255)); while (hi == int'(IO_CLASS));
                        b = {8'(hi), 24'($urandom)};
                    end else begin
                        b = {IO_CLASS, 16'($urandom), 6'($urandom_range(NUM_IO, 63)), 2'b00};
                    end
                end
                default: begin
                    b  = $urandom;
                    rd = 1'b1;
                    wr = 1'b1;
                end
            endcase
            do_tx(wa(b), rd, wr, dly);
        end

        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
